// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 8N1 UART receiver (LSB first, idle-high line).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (legal range 4..65535)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   uart_rx    serial line input (asynchronous to clk)
//   rx_data    last received byte, held until the next accepted byte
//   rx_valid   one-clk pulse, rx_data has just been updated
//   rx_busy    high while a frame is in progress
//   frame_err  one-clk pulse on a low stop bit
//
// Build option:
//   UART_RX_FRAME_ERR_EN  when defined, a low stop bit raises frame_err and drops
//                         the byte; when undefined, frame_err is tied low and the
//                         byte is delivered regardless of the stop bit.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  // Set after a low stop sample: stay in StStop until the line returns high.
  logic        brk_q, brk_d;
  logic        meta_q, rxs_q;
`ifdef UART_RX_FRAME_ERR_EN
  logic        ferr_q, ferr_d;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= uart_rx;
      rxs_q  <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    brk_d   = brk_q;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          // A high line at mid start bit is a glitch: abandon silently.
          state_d = rxs_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (brk_q) begin
          if (rxs_q) begin
            brk_d   = 1'b0;
            state_d = StIdle;
          end
        end else if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
`ifdef UART_RX_FRAME_ERR_EN
            ferr_d  = 1'b1;
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
            brk_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end
  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_busy  = (state_q != StIdle);

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, meaning clk cycles per UART bit (12 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port uart_rx  input  1  serial line; idle high; 8N1 framing, LSB first.
REQ-005 SHALL have port rx_data  output  8  last received byte; held until the next accepted byte.
REQ-006 SHALL have port rx_valid  output  1  one-clk pulse; rx_data updated and valid.
REQ-007 SHALL have port rx_busy  output  1  high while a frame is being received (state != IDLE).
REQ-008 SHALL have port frame_err  output  1  one-clk pulse on a bad stop bit.

Function
REQ-009 SHALL pass uart_rx through a 2-flop synchronizer; the flops reset to 1, and all decoding uses the synchronized signal rxs.
REQ-010 SHALL implement the states IDLE, START, DATA, STOP, plus a bit-period counter and a 3-bit bit index.
REQ-011 IDLE: rxs == 0 -> START with the counter cleared; otherwise remain in IDLE.
REQ-012 START: at counter == CLKS_PER_BIT/2 - 1 (floor), sample rxs; 0 -> DATA with the counter cleared; 1 (glitch) -> IDLE with no output pulse.
REQ-013 DATA: at counter == CLKS_PER_BIT - 1, sample rxs into shift bit[index], LSB first, then clear the counter; after index 7 -> STOP.
REQ-014 STOP: at counter == CLKS_PER_BIT - 1, sample rxs; 1 -> load rx_data from the shift register, pulse rx_valid, go to IDLE.
REQ-015 STOP with sampled 0: behaviour per REQ-022/REQ-023; the FSM then waits in STOP until rxs == 1 before entering IDLE (break handling).
REQ-016 rx_valid and frame_err SHALL each be high for exactly one clk, in the cycle after the stop-bit sample, and never both high together.
REQ-017 Latency: from the first cycle rxs is low, rx_valid SHALL rise after CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clks (±1).
REQ-018 Back-to-back frames: a start edge in the first cycle after returning to IDLE SHALL be accepted, with no dead time beyond that cycle.
REQ-019 rx_data SHALL NOT change except at an rx_valid pulse; the shift register SHALL never be visible mid-frame.

Reset
REQ-020 rst SHALL force state IDLE, counter = 0, index = 0, shift register = 0x00, rx_data = 0x00, rx_valid = 0, rx_busy = 0, frame_err = 0, and synchronizer flops = 1, asynchronously.
REQ-021 rst asserted mid-frame SHALL discard the partial byte; after release, the first falling edge starts a fresh frame.

Configuration
REQ-022 With macro UART_RX_FRAME_ERR_EN defined: a low stop sample pulses frame_err, rx_valid stays low, and rx_data is unchanged.
REQ-023 Without UART_RX_FRAME_ERR_EN: frame_err is tied 0; a low stop sample still loads rx_data and pulses rx_valid (byte delivered regardless); the break wait of REQ-015 still applies.

Verification (bench CLKS_PER_BIT = 16)
REQ-024 Send 0xA5 in 8N1 -> one rx_valid pulse with rx_data = 0xA5, frame_err = 0, latency per REQ-017.
REQ-025 Send 0x00 then 0xFF back-to-back with zero idle gap -> two rx_valid pulses, rx_data 0x00 then 0xFF.
REQ-026 Drive a 5-clk low glitch on idle line -> no rx_valid, rx_busy drops within 9 clks, FSM back in IDLE.
REQ-027 Send 0x3C with stop bit low, held low 40 clks -> with UART_RX_FRAME_ERR_EN: frame_err pulse, rx_data keeps its previous value; without: rx_valid with 0x3C. In both cases the next frame 0x5A is received correctly.
REQ-028 Assert rst during bit 4 of 0x81, release, send 0x42 -> no pulse for 0x81; rx_valid with rx_data = 0x42.
REQ-029 Hold uart_rx high for 1000 clks after reset -> rx_busy, rx_valid and frame_err stay 0, rx_data = 0x00.
